reg_file_writeback: RTL



---
 rtl/reg_file_writeback.sv | 114 +++++++++++
 1 files changed

// File: rtl/reg_file_writeback.sv
// rtl/reg_file_writeback.sv - IITB RISC write-back stage: 8x16 register file, single/multi-register commit
// Two read ports forward same-cycle commits; R7 writes are reported to fetch one cycle later.
module reg_file_writeback #(
  parameter int NREG   = 8,
  parameter int DW     = 16,
  parameter int PC_REG = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [1:0]      wb_op,
  input  logic [2:0]      wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic [NREG-1:0] wb_mask,
  input  logic            beat_valid,
  output logic            beat_ready,
  input  logic [DW-1:0]   beat_data,
  output logic [2:0]      beat_reg,
  output logic            busy,
  input  logic [2:0]      rd_addr_a,
  output logic [DW-1:0]   rd_data_a,
  input  logic [2:0]      rd_addr_b,
  output logic [DW-1:0]   rd_data_b,
  output logic            pc_wr_en,
  output logic [DW-1:0]   pc_wr_data
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MULTI   = 1'b1;
  localparam logic [1:0] OP_SINGLE = 2'b01;
  localparam logic [1:0] OP_MULTI  = 2'b10;
  localparam logic [2:0] PC_IDX    = 3'(PC_REG);

  logic [0:0]      r_state;
  logic [NREG-1:0] r_rem;
  logic [DW-1:0]   r_regs [NREG];
  logic            r_pc_wr_en;
  logic [DW-1:0]   r_pc_wr_data;

  logic            w_idle;
  logic            w_wb_acc;
  logic            w_single;
  logic            w_multi;
  logic            w_beat_acc;
  logic            w_we;
  logic [2:0]      w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [2:0]      w_beat_reg;
  logic [NREG-1:0] w_rem_next;

  assign w_idle     = (r_state == S_IDLE);
  assign wb_ready   = !reset && !flush && w_idle;
  assign beat_ready = !reset && !flush && !w_idle;
  assign busy       = !reset && !w_idle;

  assign w_wb_acc   = wb_valid && wb_ready;
  assign w_single   = w_wb_acc && (wb_op == OP_SINGLE);
  assign w_multi    = w_wb_acc && (wb_op == OP_MULTI);
  assign w_beat_acc = beat_valid && beat_ready;

  // Lowest set bit of the remaining mask picks the register for the current beat.
  always_comb begin
    w_beat_reg = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_rem[i]) w_beat_reg = 3'(i);
    end
  end

  assign beat_reg   = w_beat_reg;
  assign w_rem_next = r_rem & ~(NREG'(1) << w_beat_reg);

  // Single accept and beat accept are exclusive since they need different states.
  assign w_we    = w_single || w_beat_acc;
  assign w_waddr = w_beat_acc ? w_beat_reg : wb_addr;
  assign w_wdata = w_beat_acc ? beat_data  : wb_data;

  assign rd_data_a = (w_we && (w_waddr == rd_addr_a)) ? w_wdata : r_regs[rd_addr_a];
  assign rd_data_b = (w_we && (w_waddr == rd_addr_b)) ? w_wdata : r_regs[rd_addr_b];

  assign pc_wr_en   = r_pc_wr_en;
  assign pc_wr_data = r_pc_wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_pc_wr_en   <= 1'b0;
      r_pc_wr_data <= '0;
    end else begin
      r_pc_wr_en <= 1'b0;
      if (w_we) begin
        r_regs[w_waddr] <= w_wdata;
        if (w_waddr == PC_IDX) begin
          r_pc_wr_en   <= 1'b1;
          r_pc_wr_data <= w_wdata;
        end
      end
      if (flush) begin
        r_state <= S_IDLE;
        r_rem   <= '0;
      end else if (w_multi) begin
        r_rem   <= wb_mask;
        r_state <= (wb_mask != '0) ? S_MULTI : S_IDLE;
      end else if (w_beat_acc) begin
        r_rem <= w_rem_next;
        if (w_rem_next == '0) r_state <= S_IDLE;
      end
    end
  end

endmodule
